// File: rtl/cdc_pulse_sync_multi.sv
// Multi-channel async-level to fast_clk event synchronizer with per-channel pending-event counters.
// pulse_out follows an input change by STAGES cycles; evt_count updates one cycle after pulse_out.
module cdc_pulse_sync_multi #(
  parameter int CHANNELS = 4,
  parameter int STAGES   = 2,
  parameter int EDGE     = 0,
  parameter int CNT_W    = 4
) (
  input  logic                      fast_clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       async_in,
  output logic [CHANNELS-1:0]       pulse_out,
  output logic [CHANNELS-1:0]       evt_valid,
  input  logic [CHANNELS-1:0]       evt_ready,
  output logic [CHANNELS*CNT_W-1:0] evt_count,
  output logic [CHANNELS-1:0]       overflow,
  input  logic [CHANNELS-1:0]       ovf_clr
);

  localparam int WU_MAX = STAGES + 1;
  localparam int WU_W   = $clog2(WU_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Events are masked until the synchronizers and history flops hold real input values,
  // so an input already asserted at reset release is absorbed silently.
  logic [WU_W-1:0] wu_cnt;
  logic            warm_done;

  assign warm_done = (wu_cnt == WU_W'(WU_MAX));

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      wu_cnt <= '0;
    end else if (!warm_done) begin
      wu_cnt <= wu_cnt + WU_W'(1);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [STAGES-1:0] sync_ff;
    logic              hist;
    logic              sync_last;
    logic              evt_raw;
    logic              evt;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic              inc;
    logic              dec;
    logic              full;

    // Plain shift chain: nothing may sit between synchronizer flops.
    always_ff @(posedge fast_clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_ff <= '0;
        hist    <= 1'b0;
      end else begin
        sync_ff <= {sync_ff[STAGES-2:0], async_in[i]};
        hist    <= sync_ff[STAGES-1];
      end
    end

    assign sync_last = sync_ff[STAGES-1];

    if (EDGE == 0) begin : g_rise
      assign evt_raw = sync_last & ~hist;
    end else if (EDGE == 1) begin : g_fall
      assign evt_raw = ~sync_last & hist;
    end else begin : g_both
      assign evt_raw = sync_last ^ hist;
    end

    assign evt  = evt_raw & warm_done;
    assign inc  = evt;
    assign dec  = (cnt != '0) & evt_ready[i];
    assign full = (cnt == CNT_MAX);

    always_ff @(posedge fast_clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        if (inc && !dec && !full) begin
          cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc) begin
          cnt <= cnt - CNT_W'(1);
        end
        // A lost event outranks a same-cycle clear.
        if (inc && !dec && full) begin
          ovf <= 1'b1;
        end else if (ovf_clr[i]) begin
          ovf <= 1'b0;
        end
      end
    end

    assign pulse_out[i]                  = evt;
    assign evt_valid[i]                  = (cnt != '0);
    assign evt_count[i*CNT_W +: CNT_W]   = cnt;
    assign overflow[i]                   = ovf;
  end

endmodule

// File: tb/tb_cdc_pulse_sync_multi.sv
// Directed bench for cdc_pulse_sync_multi: rising (CNT_W=2), both-edge and falling instances.
module tb_cdc_pulse_sync_multi;

  logic fast_clk = 1'b0;
  logic rst_n;
  always #5 fast_clk = ~fast_clk;

  // Rising-edge instance, 2-bit counters
  logic [3:0] a_r, rdy_r, clr_r, pulse_r, valid_r, ovf_r;
  logic [7:0] cnt_r;
  // Both-edge instance
  logic [3:0] a_b, rdy_b, clr_b, pulse_b, valid_b, ovf_b;
  logic [15:0] cnt_b;
  // Falling-edge instance
  logic [3:0] a_f, rdy_f, clr_f, pulse_f, valid_f, ovf_f;
  logic [15:0] cnt_f;

  cdc_pulse_sync_multi #(.CHANNELS(4), .STAGES(2), .EDGE(0), .CNT_W(2)) dut_r (
    .fast_clk(fast_clk), .rst_n(rst_n), .async_in(a_r), .pulse_out(pulse_r),
    .evt_valid(valid_r), .evt_ready(rdy_r), .evt_count(cnt_r), .overflow(ovf_r), .ovf_clr(clr_r));

  cdc_pulse_sync_multi #(.CHANNELS(4), .STAGES(2), .EDGE(2), .CNT_W(4)) dut_b (
    .fast_clk(fast_clk), .rst_n(rst_n), .async_in(a_b), .pulse_out(pulse_b),
    .evt_valid(valid_b), .evt_ready(rdy_b), .evt_count(cnt_b), .overflow(ovf_b), .ovf_clr(clr_b));

  cdc_pulse_sync_multi #(.CHANNELS(4), .STAGES(2), .EDGE(1), .CNT_W(4)) dut_f (
    .fast_clk(fast_clk), .rst_n(rst_n), .async_in(a_f), .pulse_out(pulse_f),
    .evt_valid(valid_f), .evt_ready(rdy_f), .evt_count(cnt_f), .overflow(ovf_f), .ovf_clr(clr_f));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge fast_clk);
    #1;
  endtask

  typedef struct packed {
    logic       a;
    logic       rdy;
    logic       clr;
    logic       p;
    logic       v;
    logic [1:0] n;
    logic       o;
  } vec_t;

  vec_t vec [27];

  initial begin
    int stray;
    int np;
    int dbl;
    logic prev;

    vec = '{
      '{1'b1,1'b0,1'b0, 1'b0,1'b0,2'd0,1'b0},
      '{1'b1,1'b0,1'b0, 1'b1,1'b0,2'd0,1'b0},
      '{1'b0,1'b0,1'b0, 1'b0,1'b1,2'd1,1'b0},
      '{1'b0,1'b0,1'b0, 1'b0,1'b1,2'd1,1'b0},
      '{1'b1,1'b0,1'b0, 1'b0,1'b1,2'd1,1'b0},
      '{1'b1,1'b0,1'b0, 1'b1,1'b1,2'd1,1'b0},
      '{1'b0,1'b0,1'b0, 1'b0,1'b1,2'd2,1'b0},
      '{1'b0,1'b0,1'b0, 1'b0,1'b1,2'd2,1'b0},
      '{1'b1,1'b0,1'b0, 1'b0,1'b1,2'd2,1'b0},
      '{1'b1,1'b0,1'b0, 1'b1,1'b1,2'd2,1'b0},
      '{1'b0,1'b0,1'b0, 1'b0,1'b1,2'd3,1'b0},
      '{1'b0,1'b0,1'b0, 1'b0,1'b1,2'd3,1'b0},
      '{1'b1,1'b0,1'b0, 1'b0,1'b1,2'd3,1'b0},
      '{1'b1,1'b0,1'b0, 1'b1,1'b1,2'd3,1'b0},
      '{1'b0,1'b0,1'b0, 1'b0,1'b1,2'd3,1'b1},
      '{1'b0,1'b0,1'b1, 1'b0,1'b1,2'd3,1'b0},
      '{1'b1,1'b0,1'b0, 1'b0,1'b1,2'd3,1'b0},
      '{1'b1,1'b0,1'b0, 1'b1,1'b1,2'd3,1'b0},
      '{1'b0,1'b1,1'b0, 1'b0,1'b1,2'd3,1'b0},
      '{1'b0,1'b1,1'b0, 1'b0,1'b1,2'd2,1'b0},
      '{1'b0,1'b1,1'b0, 1'b0,1'b1,2'd1,1'b0},
      '{1'b1,1'b0,1'b0, 1'b0,1'b1,2'd1,1'b0},
      '{1'b1,1'b0,1'b0, 1'b1,1'b1,2'd1,1'b0},
      '{1'b0,1'b1,1'b0, 1'b0,1'b1,2'd1,1'b0},
      '{1'b0,1'b1,1'b0, 1'b0,1'b0,2'd0,1'b0},
      '{1'b0,1'b1,1'b0, 1'b0,1'b0,2'd0,1'b0},
      '{1'b0,1'b0,1'b0, 1'b0,1'b0,2'd0,1'b0}
    };

    rst_n = 1'b0;
    a_r = 4'hF; a_b = 4'hF; a_f = 4'hF;
    rdy_r = '0; rdy_b = '0; rdy_f = '0;
    clr_r = '0; clr_b = '0; clr_f = '0;

    // Reset with all inputs high: everything reads zero.
    #1;
    chk("rst_pulse_r", {28'b0, pulse_r}, 32'h0);
    chk("rst_count_r", {24'b0, cnt_r}, 32'h0);
    repeat (3) tick();
    chk("rst_valid_all", {20'b0, valid_r, valid_b, valid_f}, 32'h0);
    chk("rst_count_bf", {cnt_b, cnt_f}, 32'h0);
    chk("rst_ovf_all", {20'b0, ovf_r, ovf_b, ovf_f}, 32'h0);

    // Release with levels already high: warmup must hide the apparent rise.
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if ((pulse_r | pulse_b | pulse_f) != 4'h0) stray++;
    end
    chk("warmup_no_pulse", stray, 0);
    chk("warmup_count_r", {24'b0, cnt_r}, 32'h0);
    chk("warmup_count_b", {16'b0, cnt_b}, 32'h0);

    // Simultaneous falls on every channel of the falling-edge instance.
    a_f = 4'h0;
    tick();
    chk("fall_e1_pulse", {28'b0, pulse_f}, 32'h0);
    tick();
    chk("fall_e2_pulse", {28'b0, pulse_f}, 32'hF);
    tick();
    chk("fall_e3_pulse", {28'b0, pulse_f}, 32'h0);
    chk("fall_count", {16'b0, cnt_f}, 32'h1111);
    chk("fall_valid", {28'b0, valid_f}, 32'hF);
    chk("fall_b_quiet", {16'b0, cnt_b}, 32'h0);

    // Reset discards pending counts.
    rst_n = 1'b0;
    a_r = 4'h0; a_b = 4'h0;
    repeat (2) tick();
    chk("rst2_count_f", {16'b0, cnt_f}, 32'h0);
    chk("rst2_valid_f", {28'b0, valid_f}, 32'h0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Per-cycle table on channel 0 of the rising instance (CNT_W=2).
    for (int i = 0; i < 27; i++) begin
      a_r[0]   = vec[i].a;
      rdy_r[0] = vec[i].rdy;
      clr_r[0] = vec[i].clr;
      tick();
      chk($sformatf("row%0d_pulse", i), {28'b0, pulse_r}, {31'b0, vec[i].p});
      chk($sformatf("row%0d_valid", i), {28'b0, valid_r}, {31'b0, vec[i].v});
      chk($sformatf("row%0d_count", i), {24'b0, cnt_r}, {30'b0, vec[i].n});
      chk($sformatf("row%0d_ovf", i), {28'b0, ovf_r}, {31'b0, vec[i].o});
    end
    rdy_r = '0; clr_r = '0;

    // Toggle-encoded source: five toggles, three cycles apart, no pops.
    np = 0; dbl = 0; stray = 0; prev = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k < 5) a_b[1] = ~a_b[1];
      for (int j = 0; j < 3; j++) begin
        tick();
        if ((pulse_b & 4'b1101) != 4'h0) stray++;
        if (pulse_b[1]) begin
          np++;
          if (prev) dbl++;
        end
        prev = pulse_b[1];
      end
    end
    chk("toggle_pulses", np, 5);
    chk("toggle_single_cycle", dbl, 0);
    chk("toggle_stray", stray, 0);
    chk("toggle_count", {16'b0, cnt_b}, 32'h0050);
    chk("toggle_valid", {28'b0, valid_b}, 32'h2);

    // Build count 2 on channel 2, put an event in flight on channel 3, then reset.
    for (int k = 0; k < 2; k++) begin
      a_r[2] = 1'b1; tick(); tick();
      a_r[2] = 1'b0; tick(); tick();
    end
    chk("pre_rst_count", {24'b0, cnt_r}, 32'h20);
    a_r[3] = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pulse", {28'b0, pulse_r}, 32'h0);
    chk("midrst_valid", {28'b0, valid_r}, 32'h0);
    chk("midrst_count", {24'b0, cnt_r}, 32'h0);
    chk("midrst_ovf", {28'b0, ovf_r}, 32'h0);
    stray = 0;
    repeat (3) begin
      tick();
      if (pulse_r != 4'h0) stray++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pulse_r != 4'h0) stray++;
    end
    chk("postrst_no_pulse", stray, 0);
    chk("postrst_count", {24'b0, cnt_r}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_pulse_sync_multi.md
CDC_PULSE_SYNC_MULTI -- requirements
Module: cdc_pulse_sync_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, meaning number of independent asynchronous input channels (1..32).
REQ-002 SHALL have parameter STAGES, default 2, meaning synchronizer flop depth per channel (2..4).
REQ-003 SHALL have parameter EDGE, default 0, meaning detected event: 0 rising, 1 falling, 2 both (toggle-encoded source).
REQ-004 SHALL have parameter CNT_W, default 4, meaning per-channel pending-event counter width (1..8).
REQ-005 SHALL use one clock and an asynchronous, active-low reset: fast_clk and rst_n.
REQ-006 fast_clk  input  1  destination-domain clock; all state in this domain.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 async_in  input  CHANNELS  asynchronous level/toggle inputs from other domains.
REQ-009 pulse_out  output  CHANNELS  one-cycle pulse per detected event.
REQ-010 evt_valid  output  CHANNELS  channel has at least one pending event.
REQ-011 evt_ready  input  CHANNELS  consumer pops one pending event.
REQ-012 evt_count  output  CHANNELS*CNT_W  pending count, channel i at bits [i*CNT_W +: CNT_W].
REQ-013 overflow  output  CHANNELS  sticky: event lost to counter saturation.
REQ-014 ovf_clr  input  CHANNELS  clears overflow bit per channel.

Function
REQ-015 Each channel SHALL pass async_in through STAGES flops; no logic between synchronizer flops.
REQ-016 A history flop SHALL hold the previous synchronized value; event = rise (sync & ~hist), fall (~sync & hist) or change (sync ^ hist) per EDGE.
REQ-017 Latency: with E1 = first fast_clk edge sampling the new level, pulse_out SHALL be high from edge E_STAGES to edge E_(STAGES+1), exactly one cycle.
REQ-018 Input levels held under 1 fast_clk period MAY be missed; held >= 2 periods SHALL be detected exactly once.
REQ-019 A warmup counter SHALL suppress events for STAGES+1 cycles after reset release, loading hist with the synchronized value so a level high at reset produces no event.
REQ-020 Counter update per cycle: inc = event; dec = evt_valid & evt_ready; inc & dec -> unchanged; inc only -> +1; dec only -> -1.
REQ-021 evt_valid SHALL equal (count != 0), combinational from the count register.
REQ-022 evt_ready while count = 0 SHALL be ignored; count never wraps below 0.
REQ-023 At count = 2^CNT_W-1: inc without dec -> count holds, overflow set next cycle; inc with dec -> count holds, overflow unchanged.
REQ-024 overflow SHALL stay set until ovf_clr; if set and clear coincide, set wins.
REQ-025 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be counted.

Reset
REQ-026 On rst_n low, asynchronously: synchronizer flops, hist, counts, overflow and warmup counter SHALL be 0; pulse_out, evt_valid, evt_count, overflow SHALL read 0.
REQ-027 Reset asserted mid-operation SHALL discard pending counts and in-flight events; no pulse_out during reset or warmup.
REQ-028 Reset deassertion SHALL be synchronized to fast_clk externally; block assumes a clean release.

Verification
REQ-029 STAGES=2, EDGE=0: async_in[0] 0->1 sampled at E1 -> pulse_out[0] high exactly between E2 and E3, evt_count[0]=1, evt_valid[0]=1.
REQ-030 EDGE=2: toggle async_in[1] 5 times, 3 cycles apart, evt_ready low -> 5 single-cycle pulses, evt_count[1]=5.
REQ-031 CNT_W=2: 4 events, no pops -> count 3, overflow=1; pulse ovf_clr -> overflow=0; event with simultaneous pop at count 3 -> count 3, overflow 0.
REQ-032 Event and pop in same cycle at count 1 -> count stays 1; pop at count 0 -> count stays 0.
REQ-033 async_in all ones during reset, release -> no pulse_out, all counts 0 after warmup; subsequent falls with EDGE=1 -> one pulse each.
REQ-034 rst_n pulsed low with count=2 and event in flight -> all outputs 0 immediately, no pulse after release.
